// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg
// Shared types and constants for the traffic light controller front end.
//   light_t      : light code driven by the controller FSM (2'b11 reads as RED)
//   chan_state_t : per-approach request channel state
//   CNT_W        : width of every per-channel counter
//   sat_inc      : saturating increment used by all counters
// ---------------------------------------------------------------------------
package tlc_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10
    } light_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUALIFY = 3'd1,
        REQUEST = 3'd2,
        SERVED  = 3'd3,
        HOLDOFF = 3'd4
    } chan_state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/sensor_channel.sv
// ---------------------------------------------------------------------------
// sensor_channel
// One approach of the loop-detector conditioner: 2-flop synchroniser,
// debounce / request-latch / service / holdoff state machine.
// Optional build macro: SENSOR_STUCK_DETECT_EN (adds stuck-loop detection).
// Ports:
//   clk_i    in  system clock, rising edge
//   rst_ni   in  asynchronous active-low reset
//   raw_i    in  raw asynchronous loop detector input
//   l_i      in  light code for this approach from the controller FSM
//   s_o      out registered request (1 only in REQUEST)
//   fault_o  out stuck-loop flag (only with SENSOR_STUCK_DETECT_EN)
// ---------------------------------------------------------------------------
module sensor_channel
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 8
`ifdef SENSOR_STUCK_DETECT_EN
    ,
    parameter int STUCK_CYCLES    = 200
`endif
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       raw_i,
    input  logic [1:0] l_i,
    output logic       s_o
`ifdef SENSOR_STUCK_DETECT_EN
    ,
    output logic       fault_o
`endif
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             raw_s;
    chan_state_t      state_q;
    chan_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             s_q;
    logic             s_d;
    logic             is_green_s;
    logic             is_red_s;

`ifdef SENSOR_STUCK_DETECT_EN
    localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(STUCK_CYCLES);
    logic [CNT_W-1:0] stuck_q;
    logic [CNT_W-1:0] stuck_d;
    logic             fault_q;
    logic             fault_d;
`endif

    assign raw_s      = sync2_q;
    assign is_green_s = (l_i == GREEN);
    // 2'b11 is not a legal code and is read as RED (fail-safe).
    assign is_red_s   = (l_i != GREEN) && (l_i != YELLOW);

    // Two-flop synchroniser for the asynchronous loop input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, counter and request decode; L-driven moves take precedence over raw.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (raw_s && !is_green_s) begin
                    state_d = QUALIFY;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            QUALIFY: begin
                if (!raw_s || is_green_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = REQUEST;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = sat_inc(cnt_q);
                end
            end
            REQUEST: begin
                if (is_green_s) begin
                    state_d = SERVED;
                end else begin
                    state_d = REQUEST;
                end
            end
            SERVED: begin
                if (is_red_s) begin
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                end else begin
                    state_d = SERVED;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef SENSOR_STUCK_DETECT_EN
        // Stuck counter runs on raw_s in every state; a stuck loop parks the channel in IDLE.
        if (raw_s) begin
            stuck_d = sat_inc(stuck_q);
            fault_d = fault_q || (stuck_d >= STUCK_LIM);
        end else begin
            stuck_d = '0;
            fault_d = 1'b0;
        end
        if (fault_d) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            state_d = state_d;
        end
`endif

        s_d = (state_d == REQUEST);
    end

    // Channel state, shared counter and registered request output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
        end
    end

`ifdef SENSOR_STUCK_DETECT_EN
    // Stuck-loop counter and fault flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stuck_q <= '0;
            fault_q <= 1'b0;
        end else begin
            stuck_q <= stuck_d;
            fault_q <= fault_d;
        end
    end

    assign fault_o = fault_q;
`endif

    assign s_o = s_q;

endmodule

// File: rtl/sensor_conditioner.sv
// ---------------------------------------------------------------------------
// sensor_conditioner
// Front end of the traffic light controller: conditions three raw loop
// detector inputs into latched requests S1..S3, closing the loop on the
// controller's light codes L1..L3.
// Optional build macro: SENSOR_STUCK_DETECT_EN (adds Fault[2:0]).
// Ports:
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   Raw1..3    in   raw asynchronous loop detectors
//   L1..3      in   2-bit light codes (RED=00, GREEN=01, YELLOW=10, 11=RED)
//   S1..3      out  registered requests
//   Fault[2:0] out  per-channel stuck-loop flags (macro builds only)
// ---------------------------------------------------------------------------
module sensor_conditioner
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 8
`ifdef SENSOR_STUCK_DETECT_EN
    ,
    parameter int STUCK_CYCLES    = 200
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Raw1,
    input  logic       Raw2,
    input  logic       Raw3,
    input  logic [1:0] L1,
    input  logic [1:0] L2,
    input  logic [1:0] L3,
    output logic       S1,
    output logic       S2,
    output logic       S3
`ifdef SENSOR_STUCK_DETECT_EN
    ,
    output logic [2:0] Fault
`endif
);

    logic [2:0] raw_s;
    logic [1:0] l_s [3];
    logic [2:0] s_s;

    assign raw_s  = {Raw3, Raw2, Raw1};
    assign l_s[0] = L1;
    assign l_s[1] = L2;
    assign l_s[2] = L3;

    for (genvar i = 0; i < 3; i++) begin : g_chan
        sensor_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLDOFF_CYCLES  (HOLDOFF_CYCLES)
`ifdef SENSOR_STUCK_DETECT_EN
            ,
            .STUCK_CYCLES    (STUCK_CYCLES)
`endif
        ) u_chan (
            .clk_i   (Clock),
            .rst_ni  (Reset),
            .raw_i   (raw_s[i]),
            .l_i     (l_s[i]),
            .s_o     (s_s[i])
`ifdef SENSOR_STUCK_DETECT_EN
            ,
            .fault_o (Fault[i])
`endif
        );
    end

    assign S1 = s_s[0];
    assign S2 = s_s[1];
    assign S3 = s_s[2];

endmodule

// File: tb/tb_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// tb_sensor_conditioner
// Directed bench for sensor_conditioner with default parameters
// (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8). Requests are checked as the vector
// {S3,S2,S1}. Posedges fall at t=10,20,...; inputs change and outputs are
// sampled on the negedges in between.
// ---------------------------------------------------------------------------
module tb_sensor_conditioner;

    logic       clk;
    logic       rst_n;
    logic       raw1, raw2, raw3;
    logic [1:0] l1, l2, l3;
    logic       s1, s2, s3;
`ifdef SENSOR_STUCK_DETECT_EN
    logic [2:0] fault;
`endif

    int tests_run;
    int tests_failed;

    sensor_conditioner dut (
        .Clock (clk),
        .Reset (rst_n),
        .Raw1  (raw1),
        .Raw2  (raw2),
        .Raw3  (raw3),
        .L1    (l1),
        .L2    (l2),
        .L3    (l3),
        .S1    (s1),
        .S2    (s2),
        .S3    (s3)
`ifdef SENSOR_STUCK_DETECT_EN
        ,
        .Fault (fault)
`endif
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        {raw3, raw2, raw1} = 3'b111;
        l1 = 2'b00; l2 = 2'b00; l3 = 2'b00;

        // Reset held with all loops active: no requests.
        #2;
        chk("reset_hold", {s3, s2, s1}, 3'b000);
        #3;
        rst_n = 1'b1;                       // t=5, first sampling edge at t=10
        step(6);
        chk("reset_rel_6edges", {s3, s2, s1}, 3'b000);
        step(1);
        chk("reset_rel_7edges", {s3, s2, s1}, 3'b111);

        // Independence: only approach 1 is served.
        l1 = 2'b01;
        step(1);
        chk("indep_s1_clear", {s3, s2, s1}, 3'b110);

        // Mid-cycle reset pulse clears outputs without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midop_reset", {s3, s2, s1}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        {raw3, raw2, raw1} = 3'b000;
        l1 = 2'b00;
        step(3);
        chk("post_reset_idle", {s3, s2, s1}, 3'b000);

        // Glitch: 3 clocks of Raw1 never raises S1.
        raw1 = 1'b1;
        step(3);
        raw1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("glitch_3clk", {s3, s2, s1}, 3'b000);
        end

        // 6 clocks of Raw1: S1 rises on the 7th edge.
        raw1 = 1'b1;
        step(6);
        raw1 = 1'b0;
        chk("deb_6edges", {s3, s2, s1}, 3'b000);
        step(1);
        chk("deb_7edges", {s3, s2, s1}, 3'b001);

        // Approach 2: request latch, service, holdoff, re-arm.
        raw2 = 1'b1;
        step(6);
        chk("s2_6edges", {s3, s2, s1}, 3'b001);
        step(1);
        chk("s2_7edges", {s3, s2, s1}, 3'b011);
        raw2 = 1'b0;
        step(5);
        chk("s2_latched", {s3, s2, s1}, 3'b011);
        l2 = 2'b01;
        step(1);
        chk("s2_green_clear", {s3, s2, s1}, 3'b001);
        l2 = 2'b10;
        step(2);
        chk("s2_yellow_served", {s3, s2, s1}, 3'b001);
        // RED edge enters HOLDOFF; 8 holdoff edges back to IDLE, then
        // 1 edge into QUALIFY and 4 more to REQUEST: 14th edge sets S2.
        l2 = 2'b00;
        raw2 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step(1);
            chk("s2_holdoff", {s3, s2, s1}, 3'b001);
        end
        step(1);
        chk("s2_rearm", {s3, s2, s1}, 3'b011);

        // Approach 3: green suppresses, RED releases with raw_s already high
        // (1 edge to QUALIFY + 4 debounce edges).
        l3 = 2'b01;
        raw3 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("s3_green_supp", {s3, s2, s1}, 3'b011);
        end
        l3 = 2'b00;
        step(4);
        chk("s3_red_4edges", {s3, s2, s1}, 3'b011);
        step(1);
        chk("s3_red_5edges", {s3, s2, s1}, 3'b111);

        // Code 2'b11 behaves as RED: ends SERVED and re-arms via holdoff.
        l3 = 2'b01;
        step(1);
        chk("s3_served", {s3, s2, s1}, 3'b011);
        l3 = 2'b11;
        for (int i = 0; i < 13; i++) begin
            step(1);
            chk("s3_code11_holdoff", {s3, s2, s1}, 3'b011);
        end
        step(1);
        chk("s3_code11_rearm", {s3, s2, s1}, 3'b111);

`ifdef SENSOR_STUCK_DETECT_EN
        // Stuck loop on approach 1: fault after 200 raw_s-high cycles.
        raw1 = 1'b1;
        step(210);
        chk("stuck_fault", fault, 3'b001);
        chk("stuck_s1_low", {s3, s2, s1}, 3'b110);
        raw1 = 1'b0;
        step(2);
        chk("stuck_hold", fault, 3'b001);
        step(1);
        chk("stuck_clear", fault, 3'b000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
